// File: rtl/dvp_camera_tx.sv
// DVP sensor-side transmitter: turns an RGB565 pixel stream into PCLK/VSYNC/HREF/DATA with programmable frame timing.
// Optional build macro DVP_TX_TEST_PATTERN_EN adds tpat_i and an 8-bar vertical colour generator.
module dvp_camera_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10,
  parameter int PCLK_DIV = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              pwdn_i,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic              tpat_i,
`endif
  input  logic [15:0]       s_pix_data_i,
  input  logic              s_pix_valid_i,
  output logic              s_pix_ready_o,
  output logic              dvp_pclk_o,
  output logic              dvp_vsync_o,
  output logic              dvp_href_o,
  output logic [DATA_W-1:0] dvp_data_o,
  output logic              underflow_o,
  output logic              frame_done_o,
  output logic [2:0]        dbg_state_o
);

  localparam int HALF    = PCLK_DIV / 2;
  localparam int DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VM1     = (VS_LINES > V_BP) ? VS_LINES : V_BP;
  localparam int VM2     = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX   = (VM1 > VM2) ? VM1 : VM2;
  localparam int VW      = $clog2(V_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF - 1);
  localparam logic [HW-1:0]    H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0]    VS_LAST   = VW'(VS_LINES - 1);
  localparam logic [VW-1:0]    VBP_LAST  = VW'(V_BP - 1);
  localparam logic [VW-1:0]    ACT_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]    VFP_LAST  = VW'(V_FP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic              r_pclk;
  logic [HW-1:0]     r_h_cnt;
  logic [VW-1:0]     r_v_cnt;
  logic              r_vsync;
  logic              r_href;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_hold;
  logic              r_underflow;
  logic              r_frame_done;

  logic              w_tick;
  logic              w_tpat;
  logic [VW-1:0]     w_v_last;
  logic              w_h_wrap;
  logic              w_v_wrap;
  state_t            w_n_state;
  logic [HW-1:0]     w_n_h;
  logic [VW-1:0]     w_n_v;
  logic              w_frame_end;
  logic              w_n_href;
  logic              w_n_hi;
  logic [15:0]       w_pix;

  // tick: the clk cycle whose closing edge drops PCLK; everything visible on DVP advances there.
  assign w_tick = (r_state != S_IDLE) && r_pclk && (r_div == DIV_LAST);

  always_comb begin
    w_v_last = '0;
    case (r_state)
      S_VSYNC:  w_v_last = VS_LAST;
      S_VBP:    w_v_last = VBP_LAST;
      S_ACTIVE: w_v_last = ACT_LAST;
      S_VFP:    w_v_last = VFP_LAST;
      default:  w_v_last = '0;
    endcase
  end

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_v_cnt == w_v_last);

  // Position of the PCLK period that starts after the current tick.
  always_comb begin
    w_n_state   = r_state;
    w_n_h       = r_h_cnt + 1'b1;
    w_n_v       = r_v_cnt;
    w_frame_end = 1'b0;
    if (w_h_wrap) begin
      w_n_h = '0;
      w_n_v = r_v_cnt + 1'b1;
      if (w_v_wrap) begin
        w_n_v = '0;
        case (r_state)
          S_VSYNC: w_n_state = (V_BP > 0) ? S_VBP : S_ACTIVE;
          S_VBP:   w_n_state = S_ACTIVE;
          S_ACTIVE: begin
            if (V_FP > 0) begin
              w_n_state = S_VFP;
            end else begin
              w_frame_end = 1'b1;
              w_n_state   = en_i ? S_VSYNC : S_IDLE;
            end
          end
          S_VFP: begin
            w_frame_end = 1'b1;
            w_n_state   = en_i ? S_VSYNC : S_IDLE;
          end
          default: w_n_state = S_IDLE;
        endcase
      end
    end
  end

  assign w_n_href = (w_n_state == S_ACTIVE) && (w_n_h < H_ACT_END);
  assign w_n_hi   = w_n_href && !w_n_h[0];

`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [HW-1:0] w_bar;
  logic [15:0]   w_tp_pix;

  assign w_tpat = tpat_i;
  assign w_bar  = (w_n_h >> 1) / HW'(BAR_W);

  always_comb begin
    w_tp_pix = 16'h0000;
    if (w_bar < HW'(8)) w_tp_pix = BAR_RGB[w_bar[2:0]];
  end

  assign w_pix = w_tpat ? w_tp_pix : (s_pix_valid_i ? s_pix_data_i : 16'h0000);
`else
  assign w_tpat = 1'b0;
  assign w_pix  = s_pix_valid_i ? s_pix_data_i : 16'h0000;
`endif

  // Stream handshake: a pixel transfers on a clk edge iff s_pix_valid_i && s_pix_ready_o. Ready is
  // high only in the tick cycle that loads a high byte, so at most one pixel is ever held.
  assign s_pix_ready_o = w_tick && w_n_hi && !pwdn_i && !w_tpat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_pclk       <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_hold       <= '0;
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (pwdn_i) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_pclk       <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (en_i) begin
          r_state     <= S_VSYNC;
          r_vsync     <= 1'b1;
          r_underflow <= 1'b0;
        end
      end else begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_pclk <= ~r_pclk;
        end else begin
          r_div <= r_div + 1'b1;
        end
        if (w_tick) begin
          r_state      <= w_n_state;
          r_h_cnt      <= w_n_h;
          r_v_cnt      <= w_n_v;
          r_frame_done <= w_frame_end;
          r_vsync      <= (w_n_state == S_VSYNC);
          r_href       <= w_n_href;
          if ((w_n_state == S_VSYNC) && (r_state != S_VSYNC)) r_underflow <= 1'b0;
          if (w_n_hi) begin
            r_data <= DATA_W'(w_pix[15:8]);
            r_hold <= w_pix[7:0];
            if (!s_pix_valid_i && !w_tpat) r_underflow <= 1'b1;
          end else if (w_n_href) begin
            r_data <= DATA_W'(r_hold);
          end else begin
            r_data <= '0;
          end
        end
      end
    end
  end

  assign dvp_pclk_o   = r_pclk;
  assign dvp_vsync_o  = r_vsync;
  assign dvp_href_o   = r_href;
  assign dvp_data_o   = r_data;
  assign underflow_o  = r_underflow;
  assign frame_done_o = r_frame_done;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Directed bench for dvp_camera_tx using a tiny frame (11 PCLK lines, 55 PCLK frames, PCLK = clk/2).
module tb_dvp_camera_tx;

  localparam int H_ACTIVE = 4;
  localparam int H_BLANK  = 3;
  localparam int V_ACTIVE = 2;
  localparam int VS_LINES = 1;
  localparam int V_BP     = 1;
  localparam int V_FP     = 1;
  localparam int PCLK_DIV = 2;
  localparam int DATA_W   = 8;
  localparam int LINE     = 11;
  localparam int FRAME    = 55;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic en_i;
  logic pwdn_i;
  logic tpat_i;
  logic [15:0] s_pix_data_i;
  logic s_pix_valid_i;
  logic s_pix_ready_o;
  logic dvp_pclk_o;
  logic dvp_vsync_o;
  logic dvp_href_o;
  logic [DATA_W-1:0] dvp_data_o;
  logic underflow_o;
  logic frame_done_o;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  dvp_camera_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .VS_LINES(VS_LINES),
    .V_BP(V_BP), .V_FP(V_FP), .PCLK_DIV(PCLK_DIV), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_i(en_i),
    .pwdn_i(pwdn_i),
`ifdef DVP_TX_TEST_PATTERN_EN
    .tpat_i(tpat_i),
`endif
    .s_pix_data_i(s_pix_data_i),
    .s_pix_valid_i(s_pix_valid_i),
    .s_pix_ready_o(s_pix_ready_o),
    .dvp_pclk_o(dvp_pclk_o),
    .dvp_vsync_o(dvp_vsync_o),
    .dvp_href_o(dvp_href_o),
    .dvp_data_o(dvp_data_o),
    .underflow_o(underflow_o),
    .frame_done_o(frame_done_o),
    .dbg_state_o(dbg_state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int slot = 0;
  int drop_slot = -1;
  int hs_cnt = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  logic [15:0] pix_tab [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                               16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};

  // scoreboard: one entry per PCLK rising edge
  logic       cap_vs[$];
  logic       cap_href[$];
  logic [7:0] cap_data[$];
  logic       cap_uf[$];

  function automatic logic [9:0] exp_pos(input int k, input int drop);
    int line;
    int col;
    int s;
    logic [15:0] p;
    logic vs;
    logic hr;
    logic [7:0] d;
    line = k / LINE;
    col  = k % LINE;
    vs   = (line == 0);
    hr   = ((line == 2) || (line == 3)) && (col < 2 * H_ACTIVE);
    d    = 8'h00;
    if (hr) begin
      s = (line - 2) * H_ACTIVE + col / 2;
      p = (s == drop) ? 16'h0000 : pix_tab[s];
      d = (col % 2 == 1) ? p[7:0] : p[15:8];
    end
    return {vs, hr, d};
  endfunction

  task automatic clear_caps();
    cap_vs.delete();
    cap_href.delete();
    cap_data.delete();
    cap_uf.delete();
    slot = 0;
    hs_cnt = 0;
    rdy_cnt = 0;
  endtask

  // driver: advance one clk, record handshakes and PCLK-high samples, present the next pixel
  task automatic step();
    logic rdy;
    logic hs;
    rdy = s_pix_ready_o;
    hs  = s_pix_ready_o && s_pix_valid_i;
    @(posedge clk);
    #1;
    cyc++;
    if (rdy) begin
      rdy_cnt++;
      slot++;
    end
    if (hs) hs_cnt++;
    if (frame_done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (dvp_pclk_o) begin
      cap_vs.push_back(dvp_vsync_o);
      cap_href.push_back(dvp_href_o);
      cap_data.push_back(dvp_data_o[7:0]);
      cap_uf.push_back(underflow_o);
    end
    s_pix_data_i  = pix_tab[slot % 8];
    s_pix_valid_i = (slot != drop_slot);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done_o && n < budget);
    checks++;
    if (!frame_done_o) begin
      errors++;
      $display("FAIL %s: frame_done_o not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({dvp_pclk_o, dvp_vsync_o, dvp_href_o, s_pix_ready_o, underflow_o, frame_done_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got pclk/vs/href/rdy/uf/done=%b want 000000",
               {dvp_pclk_o, dvp_vsync_o, dvp_href_o, s_pix_ready_o, underflow_o, frame_done_o});
    end
    checks++;
    if (dvp_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h want 00", dvp_data_o);
    end
    checks++;
    if (dbg_state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state_o);
    end
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if ({dvp_pclk_o, dvp_vsync_o, dbg_state_o} !== 5'b0) begin
      errors++;
      $display("FAIL idle_no_en: got pclk=%b vs=%b state=%0d want 0 0 0", dvp_pclk_o, dvp_vsync_o, dbg_state_o);
    end
  endtask

  task automatic test_frame();
    int start;
    int vs_n;
    int hr_n;
    logic [9:0] e;
    clear_caps();
    drop_slot = -1;
    s_pix_data_i = pix_tab[0];
    s_pix_valid_i = 1'b1;
    start = cyc;
    en_i = 1'b1;
    wait_done(400, "frame1_done");
    checks++;
    if (last_done_cyc - start !== 111) begin
      errors++;
      $display("FAIL frame1_latency: got %0d clk want 111", last_done_cyc - start);
    end
    checks++;
    if (cap_vs.size() !== FRAME) begin
      errors++;
      $display("FAIL frame1_len: got %0d PCLK want %0d", cap_vs.size(), FRAME);
    end
    vs_n = 0;
    hr_n = 0;
    for (int k = 0; k < FRAME && k < cap_vs.size(); k++) begin
      e = exp_pos(k, -1);
      vs_n += int'(cap_vs[k]);
      hr_n += int'(cap_href[k]);
      checks++;
      if ({cap_vs[k], cap_href[k], cap_data[k]} !== e) begin
        errors++;
        $display("FAIL frame1_pos%0d: got vs=%b href=%b data=%02h want vs=%b href=%b data=%02h",
                 k, cap_vs[k], cap_href[k], cap_data[k], e[9], e[8], e[7:0]);
      end
    end
    checks++;
    if (vs_n !== 11 || hr_n !== 16) begin
      errors++;
      $display("FAIL frame1_counts: got vsync=%0d href=%0d want 11 16", vs_n, hr_n);
    end
    checks++;
    if (hs_cnt !== 8 || rdy_cnt !== 8) begin
      errors++;
      $display("FAIL frame1_handshakes: got xfer=%0d ready=%0d want 8 8", hs_cnt, rdy_cnt);
    end
    checks++;
    if (underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL frame1_underflow: got %b want 0", underflow_o);
    end
  endtask

  task automatic test_underflow();
    int d0;
    logic [9:0] e;
    clear_caps();
    drop_slot = 1;
    d0 = last_done_cyc;
    wait_done(400, "frame2_done");
    checks++;
    if (last_done_cyc - d0 !== 110) begin
      errors++;
      $display("FAIL frame_period: got %0d clk want 110", last_done_cyc - d0);
    end
    for (int k = 0; k < FRAME && k < cap_vs.size(); k++) begin
      e = exp_pos(k, 1);
      checks++;
      if ({cap_vs[k], cap_href[k], cap_data[k]} !== e) begin
        errors++;
        $display("FAIL frame2_pos%0d: got vs=%b href=%b data=%02h want vs=%b href=%b data=%02h",
                 k, cap_vs[k], cap_href[k], cap_data[k], e[9], e[8], e[7:0]);
      end
    end
    checks++;
    if (hs_cnt !== 7 || rdy_cnt !== 8) begin
      errors++;
      $display("FAIL frame2_handshakes: got xfer=%0d ready=%0d want 7 8", hs_cnt, rdy_cnt);
    end
    checks++;
    if (cap_uf.size() !== FRAME || cap_uf[22] !== 1'b0 || cap_uf[24] !== 1'b1 || cap_uf[54] !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got len=%0d uf@22=%b uf@24=%b uf@54=%b want 55 0 1 1",
               cap_uf.size(), cap_uf[22], cap_uf[24], cap_uf[54]);
    end
    checks++;
    if (underflow_o !== 1'b0 || dvp_vsync_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow_clear: got uf=%b vs=%b want 0 1", underflow_o, dvp_vsync_o);
    end
    drop_slot = -1;
  endtask

  task automatic test_en_deassert();
    int n;
    logic [9:0] e;
    clear_caps();
    n = 0;
    while (cap_vs.size() < 25 && n < 200) begin
      step();
      n++;
    end
    en_i = 1'b0;
    wait_done(400, "frame3_done");
    checks++;
    if (cap_vs.size() !== FRAME || dbg_state_o !== 3'd0 || dvp_vsync_o !== 1'b0) begin
      errors++;
      $display("FAIL en_off_finish: got len=%0d state=%0d vs=%b want 55 0 0", cap_vs.size(), dbg_state_o, dvp_vsync_o);
    end
    for (int k = 0; k < FRAME && k < cap_vs.size(); k++) begin
      e = exp_pos(k, -1);
      checks++;
      if ({cap_vs[k], cap_href[k], cap_data[k]} !== e) begin
        errors++;
        $display("FAIL frame3_pos%0d: got vs=%b href=%b data=%02h want vs=%b href=%b data=%02h",
                 k, cap_vs[k], cap_href[k], cap_data[k], e[9], e[8], e[7:0]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({dvp_pclk_o, dvp_vsync_o, dvp_href_o, dvp_data_o, s_pix_ready_o, frame_done_o} !== 13'b0) begin
        errors++;
        $display("FAIL en_off_idle%0d: got pclk=%b vs=%b href=%b data=%02h rdy=%b done=%b want all 0",
                 i, dvp_pclk_o, dvp_vsync_o, dvp_href_o, dvp_data_o, s_pix_ready_o, frame_done_o);
      end
    end
  endtask

  task automatic test_pwdn();
    int n;
    int done0;
    int start;
    logic [9:0] e;
    clear_caps();
    en_i = 1'b1;
    n = 0;
    while (cap_vs.size() < 27 && n < 200) begin
      step();
      n++;
    end
    pwdn_i = 1'b1;
    done0 = done_cnt;
    step();
    checks++;
    if ({dvp_pclk_o, dvp_vsync_o, dvp_href_o, dvp_data_o, dbg_state_o} !== 14'b0) begin
      errors++;
      $display("FAIL pwdn_immediate: got pclk=%b vs=%b href=%b data=%02h state=%0d want all 0",
               dvp_pclk_o, dvp_vsync_o, dvp_href_o, dvp_data_o, dbg_state_o);
    end
    repeat (6) step();
    checks++;
    if (done_cnt !== done0 || dvp_pclk_o !== 1'b0 || s_pix_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL pwdn_hold: got done_pulses=%0d pclk=%b rdy=%b want 0 0 0",
               done_cnt - done0, dvp_pclk_o, s_pix_ready_o);
    end
    clear_caps();
    start = cyc;
    pwdn_i = 1'b0;
    step();
    checks++;
    if (dvp_vsync_o !== 1'b1 || dvp_pclk_o !== 1'b0 || dbg_state_o !== 3'd1) begin
      errors++;
      $display("FAIL pwdn_restart: got vs=%b pclk=%b state=%0d want 1 0 1", dvp_vsync_o, dvp_pclk_o, dbg_state_o);
    end
    wait_done(400, "frame4_done");
    checks++;
    if (last_done_cyc - start !== 111 || cap_vs.size() !== FRAME || hs_cnt !== 8) begin
      errors++;
      $display("FAIL frame4_shape: got latency=%0d len=%0d xfer=%0d want 111 55 8",
               last_done_cyc - start, cap_vs.size(), hs_cnt);
    end
    for (int k = 0; k < FRAME && k < cap_vs.size(); k++) begin
      e = exp_pos(k, -1);
      checks++;
      if ({cap_vs[k], cap_href[k], cap_data[k]} !== e) begin
        errors++;
        $display("FAIL frame4_pos%0d: got vs=%b href=%b data=%02h want vs=%b href=%b data=%02h",
                 k, cap_vs[k], cap_href[k], cap_data[k], e[9], e[8], e[7:0]);
      end
    end
  endtask

`ifdef DVP_TX_TEST_PATTERN_EN
  task automatic test_tpat();
    logic [7:0] bars [8];
    bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0};
    clear_caps();
    tpat_i = 1'b1;
    drop_slot = 0;
    wait_done(400, "tpat_done");
    checks++;
    if (rdy_cnt !== 0 || underflow_o !== 1'b0 || cap_uf[54] !== 1'b0) begin
      errors++;
      $display("FAIL tpat_stream: got ready=%0d uf=%b want 0 0", rdy_cnt, cap_uf[54]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[22 + i] !== bars[i]) begin
        errors++;
        $display("FAIL tpat_byte%0d: got %02h want %02h", i, cap_data[22 + i], bars[i]);
      end
    end
    tpat_i = 1'b0;
    drop_slot = -1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    en_i = 1'b0;
    pwdn_i = 1'b0;
    tpat_i = 1'b0;
    s_pix_data_i = 16'h0000;
    s_pix_valid_i = 1'b0;
    test_reset();
    test_frame();
    test_underflow();
    test_en_deassert();
    test_pwdn();
`ifdef DVP_TX_TEST_PATTERN_EN
    test_tpat();
`endif
    en_i = 1'b0;
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_camera_tx.md
Name: dvp_camera_tx

Overview:
Synthesizable DVP camera-side transmitter: the sensor end of the DVP link that the camera controller drives (XCLK/PWDN). Consumes a 16-bit RGB565 pixel stream and emits PCLK, VSYNC, HREF and 8-bit DATA with programmable frame timing. Used as an on-chip camera model for RX-path bring-up and loopback, and as a test source for the capture pipeline.

Parameters:
H_ACTIVE, 640, active pixels per line (2 bytes each, so 2*H_ACTIVE PCLK periods with HREF high)
H_BLANK, 144, PCLK periods with HREF low after the active part of every line
V_ACTIVE, 480, active lines per frame
VS_LINES, 3, lines with VSYNC high
V_BP, 17, blank lines between VSYNC and the first active line
V_FP, 10, blank lines after the last active line
PCLK_DIV, 4, clk cycles per PCLK period; even, >= 2
DATA_W, 8, DVP data bus width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en_i  in  1  enable frame generation
pwdn_i  in  1  power down; forces idle immediately
s_pix_data_i  in  16  RGB565 pixel
s_pix_valid_i  in  1  pixel valid
s_pix_ready_o  out  1  pixel accepted when valid & ready
dvp_pclk_o  out  1  pixel clock
dvp_vsync_o  out  1  frame sync, active-high
dvp_href_o  out  1  line valid, active-high
dvp_data_o  out  DATA_W  pixel byte
underflow_o  out  1  sticky: a pixel was needed while s_pix_valid_i=0
frame_done_o  out  1  one-clk pulse at end of each frame

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, underflow_o 0.
- PCLK: internal divider toggles pclk_q every PCLK_DIV/2 clk cycles while state != IDLE; held 0 in IDLE. tick = clk cycle on which pclk_q goes 1->0. All of VSYNC/HREF/DATA and the h/v counters update only on tick, so they are stable at every PCLK rising edge.
- Counters: h_cnt 0..(2*H_ACTIVE+H_BLANK-1) in PCLK periods, wraps and increments v_cnt; v_cnt counts lines within the current state, clears on state change.
- FSM: IDLE -> VSYNC when en_i=1 and pwdn_i=0 (first tick follows one PCLK_DIV/2 half-period later). VSYNC (VS_LINES lines, vsync=1) -> VBP (V_BP lines) -> ACTIVE (V_ACTIVE lines) -> VFP (V_FP lines) -> at last tick of VFP: frame_done_o pulses; go VSYNC if en_i=1 else IDLE. A zero-length VBP/VFP state is skipped.
- en_i deassert mid-frame: current frame completes; IDLE after frame_done_o.
- pwdn_i=1: on next clk state=IDLE, pclk/vsync/href/data=0, counters cleared, no frame_done_o; pwdn_i has priority over en_i.
- HREF=1 only in ACTIVE for h_cnt < 2*H_ACTIVE. Even h_cnt: high byte (data[15:8]); odd h_cnt: low byte from internal hold register. DATA=0 whenever HREF=0.
- Handshake: s_pix_ready_o=1 for exactly the tick cycle preceding each even-h_cnt active byte; transfer iff valid=1 in that cycle. If valid=0: both bytes of that pixel output 0x00, underflow_o set. underflow_o clears on entry to VSYNC (not by rst-free means otherwise). Pixels are never buffered beyond one.
- Widths: if DATA_W > 8, bytes are zero-extended on the MSB side.

Optional Feature:
DVP_TX_TEST_PATTERN_EN: when defined, adds input tpat_i (1 bit); tpat_i=1 ignores the stream (s_pix_ready_o held 0, underflow_o never sets) and outputs 8 vertical colour bars, each H_ACTIVE/8 pixels wide, RGB565 values FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 in order, restarting each line. Without the macro the port and generator are absent.

Test Plan:
H_ACTIVE=4,H_BLANK=3,V_ACTIVE=2,VS_LINES=1,V_BP=1,V_FP=1,PCLK_DIV=2; en_i=1, stream always valid -> line=11 PCLK, frame=55 PCLK=110 clk; vsync high 11 PCLK; HREF high 8 PCLK per active line; frame_done_o every 110 clk.
Stream pixels 0x1234,0x5678 -> DATA bytes 12,34,56,78 on consecutive PCLK rises with HREF=1; 8 handshakes per frame.
Drop s_pix_valid_i for the 2nd pixel -> bytes 00,00 in its slots, underflow_o=1 until next VSYNC entry, then 0.
Deassert en_i during ACTIVE -> frame finishes, frame_done_o pulses, then PCLK stays 0, all outputs 0.
Assert pwdn_i mid-line -> next clk all outputs 0, no frame_done_o; release with en_i=1 -> fresh frame starting with VSYNC.
With DVP_TX_TEST_PATTERN_EN, H_ACTIVE=8, tpat_i=1 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; s_pix_ready_o=0.
